poseidon_arbiter: RTL and testbench
===================================

Name: poseidon_arbiter

Overview:
Shares one PoseidonTopLevel hash core between NUM_REQ independent stream requesters.
- Grants the core's input stream to one requester for a whole packet, ending on last; round-robin between packets.
- Records each granted requester ID in an in-order tag FIFO.
- Steers each output packet from the core back to the requester at the FIFO head.
- Sits between the requester-side stream masters and the poseidonInst input/output streams.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
DATA_W, 255, payload width; must match the core.
TAG_DEPTH, 8, maximum in-flight packets (granted, response not yet fully returned); power of two.

Ports:
clk  in  1  clock.
resetn  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester input valid.
req_ready  out  NUM_REQ  per-requester input ready.
req_last  in  NUM_REQ  per-requester end-of-packet.
req_payload  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
rsp_valid  out  NUM_REQ  per-requester response valid.
rsp_ready  in  NUM_REQ  per-requester response ready.
rsp_last  out  NUM_REQ  per-requester response end-of-packet.
rsp_payload  out  DATA_W  response data, broadcast to all requesters; qualified by rsp_valid.
core_in_valid  out  1  to io_input_valid.
core_in_ready  in  1  from io_input_ready.
core_in_last  out  1  to io_input_last.
core_in_payload  out  DATA_W  to io_input_payload.
core_out_valid  in  1  from io_output_valid.
core_out_ready  out  1  to io_output_ready.
core_out_last  in  1  from io_output_last.
core_out_payload  in  DATA_W  from io_output_payload.
inflight  out  clog2(TAG_DEPTH)+1  tag FIFO occupancy.
orphan_err  out  1  sticky flag; set when core_out_valid is seen while the tag FIFO is empty.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM goes to IDLE; RR pointer = 0; tag FIFO empty; inflight = 0; orphan_err = 0.
  - All req_ready, rsp_valid, core_in_valid and core_out_ready = 0.
  - The core shares resetn, so any packet in flight is discarded on both sides.
- Handshake: a transfer occurs on a rising clk edge when valid and ready are both 1.
  - Requesters must hold payload and last stable while valid is high and ready is low.
- Input FSM, IDLE:
  - If any req_valid is set and the tag FIFO is not full: select the first requester with req_valid set, searching from RR pointer upward and wrapping modulo NUM_REQ.
  - Register that requester as gnt, push gnt into the tag FIFO, and go to LOCK.
  - All req_ready = 0 and core_in_valid = 0 while in IDLE.
- Input FSM, LOCK:
  - core_in_valid = req_valid[gnt]; core_in_last = req_last[gnt]; core_in_payload = slice gnt; req_ready[gnt] = core_in_ready; all other req_ready = 0.
  - On a last-beat handshake: RR pointer = gnt+1 (wraps to 0), go to IDLE.
  - There is one idle cycle between packets. This bubble is accepted and is not optimised away.
- Grant latency: first req_valid seen in IDLE -> core_in_valid no earlier than the next cycle.
- Tag FIFO full: no new grant; the current LOCK packet always completes.
- Response path:
  - When the FIFO is non-empty, head = id: rsp_valid[id] = core_out_valid; rsp_last[id] = core_out_last; core_out_ready = rsp_ready[id]; all other rsp_valid = 0.
  - rsp_payload = core_out_payload.
  - Pop the FIFO on the core_out_last handshake.
- Empty FIFO: core_out_ready = 0; if core_out_valid = 1, set orphan_err (sticky until reset).
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- A push on a full FIFO is impossible because the grant is gated. A pop on an empty FIFO is impossible because core_out_ready is gated.
- Response order equals grant order. Requesters never see each other's responses.
- Path constraints:
  - Output-side combinational path: core_out_valid -> rsp_valid only.
  - Input-side combinational path: req_valid[gnt] -> core_in_valid only.
  - No combinational path from ready to valid on any side.

Decomposition:
- poseidon_pkg:
  - DATA_W = 255 constant.
  - Requester-ID width function idw(n) = max(1, clog2(n)).
  - FSM state enum {IDLE, LOCK}.
- Sub-module poseidon_tag_fifo: synchronous FIFO, TAG_DEPTH x idw(NUM_REQ).
  - push, pop, head, full, empty, count.
  - Asynchronous active-low reset.
  - Wrap-around read/write pointers with an extra MSB for the full/empty distinction.

Test Plan:
- Single requester 1 sends a 3-beat packet, core returns 1 beat with last -> core_in sees requester-1 payloads in order; rsp_valid = 4'b0010 for 1 cycle; inflight 0->1->0.
- Requesters 0 and 2 hold req_valid continuously, 2-beat packets each, 6 packets -> grant order 0,2,0,2,0,2; one idle cycle between packets; responses return in the same order.
- Core stalled (core_out_ready is not the limiter; core_out_valid = 0) with all 4 requesters streaming 1-beat packets, TAG_DEPTH = 8 -> exactly 8 grants, then all req_ready = 0 with inflight = 8; after one response, exactly one more grant.
- Response backpressure: head id = 3 with rsp_ready[3] = 0 for 5 cycles -> core_out_ready = 0 for those cycles; payload held; pop only on the last handshake.
- Simultaneous: response last-handshake and new grant in the same cycle with inflight = 2 -> inflight stays 2; head advances correctly.
- Reset asserted during LOCK mid-packet with inflight = 3 -> all valids/readys = 0 immediately; inflight = 0; RR = 0; after release, requester 0 is granted first; orphan_err = 0.
- Core asserts core_out_valid with an empty FIFO -> core_out_ready = 0; orphan_err = 1 and stays 1 until reset.

Source files
------------

// File: rtl/poseidon_pkg.sv
// Shared constants, types and helpers for the Poseidon core arbiter.
// Imported by the arbiter top and by its tag FIFO.
package poseidon_pkg;

    localparam int DATA_W = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Requester-ID width; a single requester still needs one bit.
    function automatic int idw(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/poseidon_tag_fifo.sv
// In-order FIFO of granted requester IDs.
// Pointers carry one extra MSB so full and empty stay distinguishable. DEPTH must be a power of two, >= 2.
module poseidon_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import poseidon_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] wr_q, wr_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [W-1:0]  mem_q [DEPTH];

    // Next-pointer computation.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = wr_q + CW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop) begin
            rd_d = rd_q + CW'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= {CW{1'b0}};
            rd_q <= {CW{1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Tag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign count = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/poseidon_arbiter.sv
// Packet-granular round-robin arbiter sharing one Poseidon hash core between NUM_REQ requesters.
// Responses are steered back in grant order using a tag FIFO of requester IDs.
module poseidon_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = poseidon_pkg::DATA_W,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_payload,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [NUM_REQ-1:0]          rsp_last,
    output logic [DATA_W-1:0]           rsp_payload,
    output logic                        core_in_valid,
    input  logic                        core_in_ready,
    output logic                        core_in_last,
    output logic [DATA_W-1:0]           core_in_payload,
    input  logic                        core_out_valid,
    output logic                        core_out_ready,
    input  logic                        core_out_last,
    input  logic [DATA_W-1:0]           core_out_payload,
    output logic [$clog2(TAG_DEPTH):0]  inflight,
    output logic                        orphan_err
);
    import poseidon_pkg::*;

    localparam int IDW = idw(NUM_REQ);
    localparam int CW  = $clog2(TAG_DEPTH) + 1;

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic           orphan_q, orphan_d;

    logic           sel_found_s;
    logic [IDW-1:0] sel_id_s;
    logic           push_s, pop_s;
    logic [IDW-1:0] head_s;
    logic           full_s, empty_s;
    logic [CW-1:0]  count_s;
    logic [DATA_W-1:0] req_slice_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice_s[g] = req_payload[g*DATA_W +: DATA_W];
    end

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        cand        = 0;
        sel_found_s = 1'b0;
        sel_id_s    = {IDW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!sel_found_s && req_valid[IDW'(cand)]) begin
                sel_found_s = 1'b1;
                sel_id_s    = IDW'(cand);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Grant FSM next state: lock a requester for a whole packet, release on last beat.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found_s && !full_s) begin
                    gnt_d   = sel_id_s;
                    push_s  = 1'b1;
                    state_d = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (req_valid[gnt_q] && core_in_ready && req_last[gnt_q]) begin
                    rr_d    = (gnt_q == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : gnt_q + IDW'(1);
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Input-stream mux; ready only ever reaches the granted requester.
    always_comb begin
        req_ready       = {NUM_REQ{1'b0}};
        core_in_valid   = 1'b0;
        core_in_last    = 1'b0;
        core_in_payload = {DATA_W{1'b0}};
        if (state_q == LOCK) begin
            core_in_valid    = req_valid[gnt_q];
            core_in_last     = req_last[gnt_q];
            core_in_payload  = req_slice_s[gnt_q];
            req_ready[gnt_q] = core_in_ready;
        end else begin
            core_in_valid = 1'b0;
        end
    end

    // Response steering to the requester at the FIFO head.
    always_comb begin
        rsp_valid      = {NUM_REQ{1'b0}};
        rsp_last       = {NUM_REQ{1'b0}};
        core_out_ready = 1'b0;
        if (!empty_s) begin
            rsp_valid[head_s] = core_out_valid;
            rsp_last[head_s]  = core_out_last;
            core_out_ready    = rsp_ready[head_s];
        end else begin
            core_out_ready = 1'b0;
        end
        pop_s    = !empty_s && core_out_valid && rsp_ready[head_s] && core_out_last;
        orphan_d = orphan_q | (empty_s & core_out_valid);
    end

    // State, grant, round-robin pointer and sticky error registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            gnt_q    <= {IDW{1'b0}};
            rr_q     <= {IDW{1'b0}};
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            orphan_q <= orphan_d;
        end
    end

    poseidon_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDW)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .push      (push_s),
        .push_data (gnt_d),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    assign rsp_payload = core_out_payload;
    assign inflight    = count_s;
    assign orphan_err  = orphan_q;

endmodule

// File: tb/tb_poseidon_arbiter.sv
// Directed self-checking bench for poseidon_arbiter: a cycle-vector table plus
// hand-written sequences for FIFO-full, backpressure, push/pop overlap, reset and orphan cases.
module tb_poseidon_arbiter;

    localparam int N  = 4;
    localparam int DW = 255;
    localparam int TD = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_valid, req_ready, req_last;
    logic [N*DW-1:0] req_payload;
    logic [N-1:0]    rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0]   rsp_payload;
    logic            core_in_valid, core_in_ready, core_in_last;
    logic [DW-1:0]   core_in_payload;
    logic            core_out_valid, core_out_ready, core_out_last;
    logic [DW-1:0]   core_out_payload;
    logic [3:0]      inflight;
    logic            orphan_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poseidon_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last), .req_payload(req_payload),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_last(rsp_last), .rsp_payload(rsp_payload),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_last(core_in_last),
        .core_in_payload(core_in_payload),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_last(core_out_last),
        .core_out_payload(core_out_payload),
        .inflight(inflight), .orphan_err(orphan_err)
    );

    typedef struct {
        bit         rst;
        logic [3:0] rv, rl;
        logic       cir, cov, col;
        logic [3:0] rr;
        logic [7:0] pay;
        logic [3:0] e_rdy;
        logic       e_civ, e_cil;
        int         e_src;
        logic [3:0] e_rv;
        logic       e_cor;
        logic [3:0] e_inf;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pay_of(input logic [7:0] p, input int id);
        return DW'({p, 4'(id)});
    endfunction

    task automatic set_pay(input logic [7:0] p);
        for (int i = 0; i < N; i++) req_payload[i*DW +: DW] = pay_of(p, i);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 4'b0000; req_last = 4'b0000; core_in_ready = 1'b1;
        rsp_ready = 4'b0000; core_out_valid = 1'b0; core_out_last = 1'b0;
        core_out_payload = {DW{1'b0}}; set_pay(8'h00);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    task automatic add(input bit rst, input logic [3:0] rv, input logic [3:0] rl, input logic cir,
                       input logic cov, input logic col, input logic [3:0] rr, input logic [7:0] pay,
                       input logic [3:0] e_rdy, input logic e_civ, input logic e_cil, input int e_src,
                       input logic [3:0] e_rv, input logic e_cor, input logic [3:0] e_inf);
        vec_t v;
        v = '{rst, rv, rl, cir, cov, col, rr, pay, e_rdy, e_civ, e_cil, e_src, e_rv, e_cor, e_inf};
        vq.push_back(v);
    endtask

    int grants;
    logic [3:0] m;
    int src;

    initial begin
        resetn = 1'b0;
        idle_inputs();

        // Single requester 1: 3-beat packet, 1-beat response.
        add(1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 4'd0);
        add(0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h01, 4'b0010, 1'b1, 1'b0, 1, 4'b0000, 1'b0, 4'd1);
        add(0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h02, 4'b0010, 1'b1, 1'b0, 1, 4'b0000, 1'b0, 4'd1);
        add(0, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h03, 4'b0010, 1'b1, 1'b1, 1, 4'b0000, 1'b0, 4'd1);
        add(0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0010, 8'h04, 4'b0000, 1'b0, 1'b0, 0, 4'b0010, 1'b1, 4'd1);
        add(0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h05, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 4'd0);

        // Requesters 0 and 2 alternate 2-beat packets; responses come back in grant order.
        for (int k = 0; k < 6; k++) begin
            src = (k % 2 == 0) ? 0 : 2;
            m   = 4'(1 << src);
            add(k == 0, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'(16 + 3*k),
                4'b0000, 1'b0, 1'b0, src, 4'b0000, 1'b0, 4'(k));
            add(0, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'(17 + 3*k),
                m, 1'b1, 1'b0, src, 4'b0000, 1'b0, 4'(k + 1));
            add(0, 4'b0101, m, 1'b1, 1'b0, 1'b0, 4'b0000, 8'(18 + 3*k),
                m, 1'b1, 1'b1, src, 4'b0000, 1'b0, 4'(k + 1));
        end
        for (int j = 0; j < 6; j++) begin
            src = (j % 2 == 0) ? 0 : 2;
            add(0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0101, 8'(8'h80 + j),
                4'b0000, 1'b0, 1'b0, 0, 4'(1 << src), 1'b1, 4'(6 - j));
        end
        add(0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 4'd0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) begin
                do_reset();
                #2;
                chk("reset_orphan", orphan_err, 1'b0);
            end
            req_valid = vq[i].rv; req_last = vq[i].rl; core_in_ready = vq[i].cir;
            core_out_valid = vq[i].cov; core_out_last = vq[i].col; rsp_ready = vq[i].rr;
            set_pay(vq[i].pay);
            core_out_payload = DW'({8'hEE, vq[i].pay});
            #2;
            chk($sformatf("v%0d_req_ready", i), req_ready, vq[i].e_rdy);
            chk($sformatf("v%0d_core_in_valid", i), core_in_valid, vq[i].e_civ);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vq[i].e_rv);
            chk($sformatf("v%0d_rsp_last", i), rsp_last, vq[i].col ? vq[i].e_rv : 4'b0000);
            chk($sformatf("v%0d_core_out_ready", i), core_out_ready, vq[i].e_cor);
            chk($sformatf("v%0d_inflight", i), inflight, vq[i].e_inf);
            if (vq[i].e_civ) begin
                chk($sformatf("v%0d_core_in_last", i), core_in_last, vq[i].e_cil);
                chk($sformatf("v%0d_core_in_payload", i), core_in_payload, pay_of(vq[i].pay, vq[i].e_src));
            end
            if (vq[i].e_rv != 4'b0000) begin
                chk($sformatf("v%0d_rsp_payload", i), rsp_payload, DW'({8'hEE, vq[i].pay}));
            end
            cyc();
        end

        // Tag FIFO fills: exactly TD grants with the core output stalled.
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111; rsp_ready = 4'b1111; set_pay(8'h30);
        grants = 0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (core_in_valid && core_in_ready) begin
                chk("full_grant_order", core_in_payload, pay_of(8'h30, grants % 4));
                grants++;
            end
            cyc();
        end
        #2;
        chk("full_grants", 32'(grants), 32'd8);
        chk("full_inflight", inflight, 4'd8);
        chk("full_req_ready", req_ready, 4'b0000);
        chk("full_core_in_valid", core_in_valid, 1'b0);
        core_out_valid = 1'b1; core_out_last = 1'b1;
        #1;
        chk("full_rsp_head", rsp_valid, 4'b0001);
        chk("full_core_out_ready", core_out_ready, 1'b1);
        cyc();
        core_out_valid = 1'b0; core_out_last = 1'b0;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (core_in_valid && core_in_ready) begin
                chk("refill_src", core_in_payload, pay_of(8'h30, 0));
                grants++;
            end
            cyc();
        end
        chk("refill_grants", 32'(grants), 32'd1);
        chk("refill_inflight", inflight, 4'd8);

        // Response backpressure on head id 3.
        do_reset();
        req_valid = 4'b1000; req_last = 4'b1000;
        cyc(); cyc();
        req_valid = 4'b0000; req_last = 4'b0000;
        core_out_valid = 1'b1; core_out_last = 1'b0; core_out_payload = DW'(16'hABCD); rsp_ready = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("bp_core_out_ready", core_out_ready, 1'b0);
            chk("bp_rsp_valid", rsp_valid, 4'b1000);
            chk("bp_rsp_payload", rsp_payload, DW'(16'hABCD));
            chk("bp_inflight", inflight, 4'd1);
            cyc();
        end
        rsp_ready = 4'b1000;
        #2;
        chk("bp_release_ready", core_out_ready, 1'b1);
        cyc();
        #2;
        chk("bp_no_pop_midpacket", inflight, 4'd1);
        core_out_last = 1'b1; core_out_payload = DW'(16'h00EF);
        #1;
        chk("bp_rsp_last", rsp_last, 4'b1000);
        cyc();
        core_out_valid = 1'b0; core_out_last = 1'b0;
        #2;
        chk("bp_pop_last", inflight, 4'd0);

        // Push and pop in the same cycle with inflight = 2.
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0010; cyc(); cyc();
        req_valid = 4'b0100; req_last = 4'b0100; cyc(); cyc();
        req_valid = 4'b1000; req_last = 4'b1000;
        core_out_valid = 1'b1; core_out_last = 1'b1; rsp_ready = 4'b1111;
        #2;
        chk("pp_inflight_before", inflight, 4'd2);
        chk("pp_rsp_valid", rsp_valid, 4'b0010);
        chk("pp_core_out_ready", core_out_ready, 1'b1);
        cyc();
        core_in_ready = 1'b0; core_out_last = 1'b0; rsp_ready = 4'b0000;
        #2;
        chk("pp_inflight_after", inflight, 4'd2);
        chk("pp_new_head", rsp_valid, 4'b0100);
        chk("pp_locked_src", core_in_payload, pay_of(8'h00, 3));

        // Reset in the middle of a locked packet with inflight = 3.
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0001; cyc(); cyc();
        req_valid = 4'b0010; req_last = 4'b0010; cyc(); cyc();
        req_valid = 4'b0100; req_last = 4'b0000; cyc(); cyc();
        #2;
        chk("mid_inflight", inflight, 4'd3);
        chk("mid_core_in_valid", core_in_valid, 1'b1);
        resetn = 1'b0; req_valid = 4'b1111; core_out_valid = 1'b1; rsp_ready = 4'b1111;
        #2;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_core_in_valid", core_in_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_core_out_ready", core_out_ready, 1'b0);
        chk("rst_inflight", inflight, 4'd0);
        chk("rst_orphan", orphan_err, 1'b0);
        cyc();
        core_out_valid = 1'b0;
        cyc();
        resetn = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; core_in_ready = 1'b1;
        #2;
        chk("post_rst_idle", core_in_valid, 1'b0);
        cyc();
        #2;
        chk("post_rst_gnt_ready", req_ready, 4'b0001);
        chk("post_rst_gnt_src", core_in_payload, pay_of(8'h00, 0));
        chk("post_rst_orphan", orphan_err, 1'b0);

        // Orphan response with an empty tag FIFO.
        do_reset();
        core_out_valid = 1'b1; core_out_last = 1'b1; rsp_ready = 4'b1111;
        #2;
        chk("orph_core_out_ready", core_out_ready, 1'b0);
        chk("orph_rsp_valid", rsp_valid, 4'b0000);
        chk("orph_before", orphan_err, 1'b0);
        cyc();
        core_out_valid = 1'b0; core_out_last = 1'b0;
        #2;
        chk("orph_set", orphan_err, 1'b1);
        cyc(); cyc(); cyc();
        chk("orph_sticky", orphan_err, 1'b1);
        do_reset();
        #2;
        chk("orph_cleared", orphan_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
